// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM arbiter: sequential host load, then neuron-major streaming fetch
// through a 2-entry skid buffer that hides the one-cycle SRAM read latency.
module weight_fetch_ctrl #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 200,
    parameter int DW    = 16,
    parameter int AW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          load_done,
    input  logic          start,
    output logic          busy,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [DW-1:0] w_data,
    output logic          w_last,
    output logic [7:0]    w_neuron,
    output logic          fetch_done,
    output logic          sram_we,
    output logic [DW-1:0] sram_d,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_q
);

    localparam logic [AW-1:0] IN_LAST   = AW'(N_IN - 1);
    localparam logic [AW-1:0] OUT_LAST  = AW'(N_OUT - 1);
    localparam logic [AW-1:0] WORD_LAST = AW'(N_IN * N_OUT - 1);
    localparam logic [AW-1:0] ONE       = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] load_cnt_q, load_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] in_idx_q, in_idx_d;
    logic [AW-1:0] neuron_idx_q, neuron_idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic [7:0]    infl_nrn_q, infl_nrn_d;
    logic          load_done_q, load_done_d;
    logic          fetch_done_q, fetch_done_d;
    logic [DW-1:0] buf_data_q [2];
    logic [DW-1:0] buf_data_d [2];
    logic          buf_last_q [2];
    logic          buf_last_d [2];
    logic [7:0]    buf_nrn_q [2];
    logic [7:0]    buf_nrn_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop, load_hs, issue;
    logic [1:0]    occ;

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        in_idx_d     = in_idx_q;
        neuron_idx_d = neuron_idx_q;
        addr_d       = addr_q;
        infl_d       = 1'b0;
        infl_last_d  = infl_last_q;
        infl_nrn_d   = infl_nrn_q;
        load_done_d  = 1'b0;
        fetch_done_d = 1'b0;
        buf_data_d   = buf_data_q;
        buf_last_d   = buf_last_q;
        buf_nrn_d    = buf_nrn_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        load_ready   = 1'b0;
        sram_we      = 1'b0;
        sram_d       = '0;
        load_hs      = 1'b0;
        issue        = 1'b0;
        pop          = (cnt_q != 2'd0) && w_ready;
        // Occupancy counts this cycle's pop so a steady stream sustains 1 word/cycle.
        occ          = cnt_q + {1'b0, infl_q} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) load_hs = 1'b1;
                else if (start) state_d = S_FETCH;
            end
            S_LOAD: begin
                load_ready = 1'b1;
                load_hs    = load_valid;
            end
            S_FETCH: issue = (occ < 2'd2);
            S_DRAIN: begin
                if (!infl_q && cnt_q == {1'b0, pop}) begin
                    fetch_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_hs) begin
            sram_we = 1'b1;
            sram_d  = load_data;
            addr_d  = load_cnt_q;
            if (load_cnt_q == WORD_LAST) begin
                load_cnt_d  = '0;
                load_done_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                load_cnt_d = load_cnt_q + ONE;
                state_d    = S_LOAD;
            end
        end

        if (issue) begin
            addr_d      = rd_cnt_q;
            infl_d      = 1'b1;
            infl_last_d = (in_idx_q == IN_LAST);
            infl_nrn_d  = neuron_idx_q[7:0];
            if (in_idx_q == IN_LAST) begin
                in_idx_d = '0;
                if (neuron_idx_q == OUT_LAST) begin
                    rd_cnt_d     = '0;
                    neuron_idx_d = '0;
                    state_d      = S_DRAIN;
                end else begin
                    neuron_idx_d = neuron_idx_q + ONE;
                    rd_cnt_d     = rd_cnt_q + ONE;
                end
            end else begin
                in_idx_d = in_idx_q + ONE;
                rd_cnt_d = rd_cnt_q + ONE;
            end
        end

        if (infl_q) begin
            buf_data_d[wr_ptr_q] = sram_q;
            buf_last_d[wr_ptr_q] = infl_last_q;
            buf_nrn_d[wr_ptr_q]  = infl_nrn_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = occ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            in_idx_q     <= '0;
            neuron_idx_q <= '0;
            addr_q       <= '0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            infl_nrn_q   <= '0;
            load_done_q  <= 1'b0;
            fetch_done_q <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
                buf_nrn_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            in_idx_q     <= in_idx_d;
            neuron_idx_q <= neuron_idx_d;
            addr_q       <= addr_d;
            infl_q       <= infl_d;
            infl_last_q  <= infl_last_d;
            infl_nrn_q   <= infl_nrn_d;
            load_done_q  <= load_done_d;
            fetch_done_q <= fetch_done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            buf_data_q   <= buf_data_d;
            buf_last_q   <= buf_last_d;
            buf_nrn_q    <= buf_nrn_d;
        end
    end

    assign sram_addr  = addr_d;
    assign busy       = (state_q != S_IDLE);
    assign load_done  = load_done_q;
    assign fetch_done = fetch_done_q;
    assign w_valid    = (cnt_q != 2'd0);
    assign w_data     = buf_data_q[rd_ptr_q];
    assign w_last     = buf_last_q[rd_ptr_q];
    assign w_neuron   = buf_nrn_q[rd_ptr_q];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl at 4x3 weights: SRAM model, per-cycle stream/write
// model check and directed literal expectations.
module tb_weight_fetch_ctrl;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int NW = NI * NO;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready, load_done, busy, w_valid, w_last, fetch_done, sram_we;
    logic        start = 1'b0;
    logic        w_ready = 1'b0;
    logic [15:0] w_data, sram_d, sram_q;
    logic [7:0]  w_neuron;
    logic [17:0] sram_addr;

    weight_fetch_ctrl #(.N_IN(NI), .N_OUT(NO), .DW(16), .AW(18)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .start(start), .busy(busy),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .w_neuron(w_neuron), .fetch_done(fetch_done), .sram_we(sram_we),
        .sram_d(sram_d), .sram_addr(sram_addr), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:NW-1];
    always @(posedge clk) begin
        if (sram_we && int'(sram_addr) < NW) mem[int'(sram_addr)] <= sram_d;
        sram_q <= (int'(sram_addr) < NW) ? mem[int'(sram_addr)] : 16'h0;
    end

    int checks = 0, failures = 0;
    int acc_cnt = 0, iss_cnt = 0, wr_exp = 0;
    int ld_pulses = 0, fd_pulses = 0, iss_total = 0, done_words = 0;
    bit fd_exp = 0, ld_exp = 0, prev_stall = 0, fd_seen = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic logic [15:0] wexp(input int k);
        return 16'(k) ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int pop;
        if (rst) begin
            acc_cnt = 0; iss_cnt = 0; wr_exp = 0;
            fd_exp = 0; ld_exp = 0; prev_stall = 0;
            return;
        end
        pop = int'(w_valid && w_ready);
        chk("load_done", int'(load_done), int'(ld_exp));
        chk("fetch_done", int'(fetch_done), int'(fd_exp));
        if (load_done) begin ld_pulses++; wr_exp = 0; end
        if (fetch_done) begin
            fd_pulses++; fd_seen = 1; done_words = acc_cnt; acc_cnt = 0; iss_cnt = 0;
        end
        ld_exp = 0;
        fd_exp = 0;
        if (sram_we) begin
            chk("wr_addr", int'(sram_addr), wr_exp);
            chk("wr_data", int'(sram_d), int'(wexp(wr_exp)));
            if (wr_exp == NW - 1) ld_exp = 1;
            wr_exp++;
        end
        if (busy && !load_ready) begin
            chk("we_in_fetch", int'(sram_we), 0);
            if (!sram_we && int'(sram_addr) == iss_cnt && iss_cnt < NW) begin
                chk("rd_window", int'((iss_cnt + 1 - acc_cnt - pop) <= 2), 1);
                iss_cnt++;
                iss_total++;
            end
        end
        if (prev_stall) chk("stall_valid", int'(w_valid), 1);
        if (w_valid) begin
            chk("w_dup", int'(acc_cnt < NW), 1);
            chk("w_data", int'(w_data), int'(wexp(acc_cnt)));
            chk("w_last", int'(w_last), int'(acc_cnt % NI == NI - 1));
            chk("w_neuron", int'(w_neuron), acc_cnt / NI);
            if (w_ready) begin
                acc_cnt++;
                if (acc_cnt == NW) fd_exp = 1;
            end
        end
        prev_stall = w_valid && !w_ready;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string n);
        chk({n, "_ctrl"}, int'({load_ready, busy, w_valid, load_done, fetch_done, sram_we, w_last}), 7'b1000000);
        chk({n, "_addr"}, int'(sram_addr), 0);
        chk({n, "_sram_d"}, int'(sram_d), 0);
        chk({n, "_w_data"}, int'(w_data), 0);
        chk({n, "_w_neuron"}, int'(w_neuron), 0);
    endtask

    task automatic run_fetch(input int max, input bit toggle, input string name);
        for (int c = 0; c < max && !fd_seen; c++) begin
            if (toggle) w_ready = pat[c % 4];
            step();
        end
        chk({name, "_timeout"}, int'(fd_seen), 1);
        chk({name, "_words"}, done_words, NW);
    endtask

    initial begin
        repeat (3) step();
        check_rst("reset");
        rst = 1'b0;
        step();

        // Load with 0-3 idle cycles between words; start during LOAD is ignored.
        for (int k = 0; k < NW; k++) begin
            for (int g = 0; g < k % 4; g++) begin
                load_valid = 1'b0;
                start = (k == 6 && g == 0);
                step();
            end
            load_valid = 1'b1;
            load_data  = wexp(k);
            start = (k == 5);
            step();
            if (k == 0) chk("load_busy", int'(busy), 1);
        end
        load_valid = 1'b0;
        start = 1'b0;
        chk("load_done_pulse", int'(load_done), 1);
        chk("load_idle", int'(busy), 0);
        step();
        chk("load_done_clear", int'(load_done), 0);
        chk("load_pulses", ld_pulses, 1);

        // Full-rate fetch.
        fd_seen = 0;
        w_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f_busy", int'(busy), 1);
        chk("f_valid_c1", int'(w_valid), 0);
        step();
        chk("f_valid_c2", int'(w_valid), 0);
        step();
        chk("f_valid_c3", int'(w_valid), 1);
        chk("f_first_data", int'(w_data), 16'hA5A5);
        step();
        chk("f_second_data", int'(w_data), 16'hA5A4);
        run_fetch(40, 1'b0, "fetch_full");
        chk("fetch_full_pulses", fd_pulses, 1);
        chk("fetch_full_idle", int'(busy), 0);

        // Fetch with ready pattern 1,0,0,1.
        fd_seen = 0;
        start = 1'b1;
        w_ready = 1'b1;
        step();
        start = 1'b0;
        run_fetch(100, 1'b1, "fetch_stall");
        chk("fetch_stall_pulses", fd_pulses, 2);

        // load_valid and start together: load wins, no fetch.
        w_ready = 1'b1;
        load_valid = 1'b1;
        load_data = wexp(0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ld_start_busy", int'(busy), 1);
        chk("ld_start_load_ready", int'(load_ready), 1);
        for (int k = 1; k < NW; k++) begin
            load_data = wexp(k);
            start = (k == 3);
            step();
        end
        load_valid = 1'b0;
        start = 1'b0;
        step();
        chk("ld_start_pulses", ld_pulses, 2);
        chk("ld_start_no_reads", iss_total, 2 * NW);
        chk("ld_start_no_fetch", fd_pulses, 2);

        // Reset in the middle of a fetch, then restart.
        fd_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && acc_cnt < 5; c++) step();
        chk("abort_head", int'(w_data), int'(wexp(5)));
        rst = 1'b1;
        #1;
        check_rst("abort_async");
        step();
        check_rst("abort_held");
        rst = 1'b0;
        repeat (3) step();
        chk("abort_no_done", fd_pulses, 2);
        fd_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("restart_valid", int'(w_valid), 1);
        chk("restart_data", int'(w_data), 16'hA5A5);
        run_fetch(40, 1'b0, "restart");
        chk("restart_pulses", fd_pulses, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Controller that owns the single-port 16-bit weight SRAM (156800 words = 784 inputs x 200 neurons) and shares it between two requesters.
- Requester 1 is a host load stream that fills the SRAM sequentially. Requester 2 is a fetch engine that streams weights in neuron-major order to the MAC datapath.
- Handles the SRAM's one-cycle read latency with a 2-entry output buffer so the datapath may apply backpressure.

Parameters:
- N_IN, 784, inputs per neuron (row length).
- N_OUT, 200, neurons (row count); total words = N_IN*N_OUT.
- DW, 16, weight width.
- AW, 18, SRAM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  host word available.
- load_data  in  DW  host weight word.
- load_ready  out  1  controller accepts a load word this cycle.
- load_done  out  1  one-cycle pulse after the final word is written.
- start  in  1  one-cycle request to stream all weights.
- busy  out  1  high in any state other than IDLE.
- w_valid  out  1  w_data valid.
- w_ready  in  1  datapath accepts the word.
- w_data  out  DW  weight word.
- w_last  out  1  word is the last input of its neuron (input index == N_IN-1).
- w_neuron  out  8  neuron index of w_data.
- fetch_done  out  1  one-cycle pulse when the last word has been accepted.
- sram_we  out  1  SRAM write enable.
- sram_d  out  DW  SRAM write data.
- sram_addr  out  AW  SRAM address.
- sram_q  in  DW  SRAM read data, valid the cycle after the address is presented with sram_we=0.

Behaviour:
- Reset: state=IDLE; all counters, buffer and in-flight flag cleared; every output 0 except load_ready=1.
  - Reset asserted mid-LOAD or mid-FETCH aborts the operation: no done pulse, and the buffer is flushed.
- States: IDLE, LOAD, FETCH, DRAIN.
- IDLE:
  - load_ready=1.
  - A load handshake (load_valid & load_ready) writes the word and moves to LOAD.
  - Otherwise start moves to FETCH.
  - If load_valid and start arrive in the same cycle, the load wins and start is dropped; it is not queued.
- LOAD:
  - load_ready=1. Each handshake drives, combinationally in that cycle, sram_we=1, sram_addr=load_cnt, sram_d=load_data; load_cnt then increments.
  - start is ignored.
  - The handshake at load_cnt=N_IN*N_OUT-1 produces load_done=1 next cycle, clears load_cnt and returns to IDLE.
  - Idle cycles (load_valid=0) are allowed indefinitely.
- FETCH:
  - load_ready=0 and sram_we=0.
  - A read is issued (sram_addr=rd_cnt, rd_cnt++, in-flight flag set) only when buffer occupancy + in-flight < 2.
  - The word returned next cycle is pushed into the buffer together with its neuron index and last flag.
  - Counters: in_idx wraps N_IN-1 -> 0 and increments neuron_idx; address = neuron_idx*N_IN + in_idx, kept as a running counter with no multiplier.
  - After issuing address N_IN*N_OUT-1, go to DRAIN.
- DRAIN:
  - No new reads.
  - When the buffer is empty and nothing is in flight, pulse fetch_done and go to IDLE.
  - fetch_done asserts the cycle after the final w_valid & w_ready.
- Output buffer:
  - 2-entry FIFO; head drives w_valid/w_data/w_last/w_neuron.
  - Pop on w_valid & w_ready; push and pop in the same cycle are allowed.
  - Outputs are stable while w_valid=1 and w_ready=0.
  - Throughput is 1 word/cycle with w_ready held high.
  - First w_valid appears 2 cycles after start is sampled (cycle 1 issue, cycle 2 data registered).
- sram_addr when not writing or reading: holds the last value; sram_d=0 when not writing.
- A start pulse during LOAD/FETCH/DRAIN is ignored.
- Widths: counters are sized to AW; w_neuron is the low 8 bits of neuron_idx.

Test Plan:
- Reset, then load all words (bench N_IN=4, N_OUT=3, data = address XOR 16'hA5A5) -> 12 writes at addresses 0..11 with matching sram_d; load_done a single pulse one cycle after the 12th handshake; busy low afterwards.
- start with w_ready=1 -> w_valid first at cycle +2; 12 consecutive words in address order; w_last high on words 3, 7, 11; w_neuron sequence 0,0,0,0,1,...,2; fetch_done one cycle after the last accept.
- Fetch with w_ready toggling 1,0,0,1 repeating -> no word lost or duplicated, data stable while stalled, no read issued when occupancy + in-flight = 2.
- load_valid and start asserted together in IDLE -> word written at address 0, state LOAD, no fetch occurs; start during LOAD has no effect.
- Assert rst at word 5 of a fetch -> next cycle all outputs at reset values, no fetch_done pulse; a subsequent start restarts at address 0.
- Load with load_valid gaps of 0–3 cycles -> addresses remain contiguous and load_done fires exactly once.
